pipelined_core: RTL and testbench

- Parametrised five-stage in-order core: fetch, decode, execute, memory, writeback.
- Successor to the fixed 16-bit pipeline. Generalises datapath width.
- Adds full operand forwarding (selectable), load-use stall detection, halt/drain and performance counters.
- Sits between an instruction memory and a data memory. Internal register file of 8 entries.

---
 rtl/core_pkg.sv | 55 +++++
 rtl/pipelined_core_hazard_unit.sv | 57 +++++
 rtl/pipelined_core.sv | 219 +++++++++++++++++++++
 tb/tb_pipelined_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the five-stage core: opcodes, instruction field
// positions, the per-stage control record and operand-source encoding.
package core_pkg;

  localparam int INSTR_W  = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int IMM_W    = 10;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 7;
  localparam int RS2_HI = 6;
  localparam int RS2_LO = 4;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // Control part of a stage register; operand/result data travel alongside.
  typedef struct packed {
    logic              valid;
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
  } stage_ctl_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EM = 2'd1,
    FWD_MW = 2'd2
  } fwd_sel_e;

  function automatic logic writes_rd(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_LDI) || (op == OP_LD);
  endfunction

  function automatic logic reads_rs1(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic reads_rs2(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/pipelined_core_hazard_unit.sv
// Combinational hazard logic: decode-stage stall and execute-stage operand
// source selection from the valid/op/rd of the downstream stages.
module pipelined_core_hazard_unit
  import core_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic              d_valid,
  input  logic [2:0]        d_op,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  stage_ctl_t        e_ctl,
  input  logic [REG_AW-1:0] e_rs1,
  input  logic [REG_AW-1:0] e_rs2,
  input  stage_ctl_t        m_ctl,
  input  stage_ctl_t        w_ctl,
  output logic              stall,
  output fwd_sel_e          fwd_a,
  output fwd_sel_e          fwd_b
);

  function automatic logic produces(input stage_ctl_t p, input logic [REG_AW-1:0] r);
    return p.valid && writes_rd(p.op) && (p.rd == r);
  endfunction

  logic uses_rs1;
  logic uses_rs2;
  assign uses_rs1 = d_valid && reads_rs1(d_op);
  assign uses_rs2 = d_valid && reads_rs2(d_op);

  generate
    if (FORWARD_EN) begin : g_forward
      logic load_in_e;
      assign load_in_e = e_ctl.valid && (e_ctl.op == OP_LD);
      // Only a load in E cannot be covered by forwarding: its data arrives at W.
      assign stall = load_in_e &&
                     ((uses_rs1 && (e_ctl.rd == d_rs1)) ||
                      (uses_rs2 && (e_ctl.rd == d_rs2)));

      always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (produces(m_ctl, e_rs1))      fwd_a = FWD_EM;
        else if (produces(w_ctl, e_rs1)) fwd_a = FWD_MW;
        if (produces(m_ctl, e_rs2))      fwd_b = FWD_EM;
        else if (produces(w_ctl, e_rs2)) fwd_b = FWD_MW;
      end
    end else begin : g_interlock
      // A producer already in W is seen through the write-through read port.
      assign stall = (uses_rs1 && (produces(e_ctl, d_rs1) || produces(m_ctl, d_rs1))) ||
                     (uses_rs2 && (produces(e_ctl, d_rs2) || produces(m_ctl, d_rs2)));
      assign fwd_a = FWD_RF;
      assign fwd_b = FWD_RF;
    end
  endgenerate

endmodule

// File: rtl/pipelined_core.sv
// Five-stage in-order core (F/D/E/M/W) with 8-entry register file, optional
// operand forwarding, load-use interlock, HLT drain and performance counters.
module pipelined_core
  import core_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 10,
  parameter int DADDR_W    = 10,
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  output logic               dmem_re,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               halted,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retire_cnt,
  output logic [31:0]        stall_cnt
);

  logic [PC_W-1:0]    pc_reg;
  logic               fetch_stop_reg;
  logic               fd_valid_reg;
  logic [INSTR_W-1:0] fd_instr_reg;

  stage_ctl_t         de_reg;
  logic [REG_AW-1:0]  de_rs1_reg;
  logic [REG_AW-1:0]  de_rs2_reg;
  logic [DATA_W-1:0]  de_a_reg;
  logic [DATA_W-1:0]  de_b_reg;
  logic [DATA_W-1:0]  de_imm_reg;

  stage_ctl_t         em_reg;
  logic [DATA_W-1:0]  em_result_reg;
  logic [DATA_W-1:0]  em_store_reg;

  stage_ctl_t         mw_reg;
  logic [DATA_W-1:0]  mw_result_reg;

  logic [DATA_W-1:0]  rf_reg [NUM_REGS];
  logic               halted_reg;
  logic [31:0]        cycle_cnt_reg;
  logic [31:0]        retire_cnt_reg;
  logic [31:0]        stall_cnt_reg;

  // Writeback
  logic              w_write;
  logic              w_hlt;
  logic              w_retire;
  logic [DATA_W-1:0] w_value;
  logic [NUM_REGS-1:0] rf_we;

  assign w_write  = mw_reg.valid && writes_rd(mw_reg.op);
  assign w_hlt    = mw_reg.valid && (mw_reg.op == OP_HLT);
  assign w_retire = mw_reg.valid && (mw_reg.op != OP_NOP);
  assign w_value  = (mw_reg.op == OP_LD) ? dmem_rdata : mw_result_reg;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf_we
      assign rf_we[gi] = w_write && (mw_reg.rd == REG_AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rf_we[i]) rf_reg[i] <= w_value;
      end
    end
  end

  // Decode
  logic [2:0]        d_op;
  logic [REG_AW-1:0] d_rd;
  logic [REG_AW-1:0] d_rs1;
  logic [REG_AW-1:0] d_rs2;
  logic              d_hlt;
  logic [DATA_W-1:0] d_a;
  logic [DATA_W-1:0] d_b;
  logic [DATA_W-1:0] d_imm;

  assign d_op  = fd_instr_reg[OP_HI:OP_LO];
  assign d_rd  = fd_instr_reg[RD_HI:RD_LO];
  assign d_rs1 = fd_instr_reg[RS1_HI:RS1_LO];
  assign d_rs2 = fd_instr_reg[RS2_HI:RS2_LO];
  assign d_hlt = fd_valid_reg && (d_op == OP_HLT);
  assign d_imm = {{(DATA_W-IMM_W){fd_instr_reg[IMM_W-1]}}, fd_instr_reg[IMM_W-1:0]};

  // Write-through: a register being written this cycle reads as its new value.
  assign d_a = (w_write && (mw_reg.rd == d_rs1)) ? w_value : rf_reg[d_rs1];
  assign d_b = (w_write && (mw_reg.rd == d_rs2)) ? w_value : rf_reg[d_rs2];

  logic     stall;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  pipelined_core_hazard_unit #(
    .FORWARD_EN(FORWARD_EN)
  ) u_hazard (
    .d_valid (fd_valid_reg),
    .d_op    (d_op),
    .d_rs1   (d_rs1),
    .d_rs2   (d_rs2),
    .e_ctl   (de_reg),
    .e_rs1   (de_rs1_reg),
    .e_rs2   (de_rs2_reg),
    .m_ctl   (em_reg),
    .w_ctl   (mw_reg),
    .stall   (stall),
    .fwd_a   (fwd_a),
    .fwd_b   (fwd_b)
  );

  // Execute
  logic [DATA_W-1:0] e_a;
  logic [DATA_W-1:0] e_b;
  logic [DATA_W-1:0] e_result;

  always_comb begin
    e_a = de_a_reg;
    e_b = de_b_reg;
    case (fwd_a)
      FWD_EM:  e_a = em_result_reg;
      FWD_MW:  e_a = w_value;
      default: e_a = de_a_reg;
    endcase
    case (fwd_b)
      FWD_EM:  e_b = em_result_reg;
      FWD_MW:  e_b = w_value;
      default: e_b = de_b_reg;
    endcase
  end

  always_comb begin
    e_result = '0;
    case (de_reg.op)
      OP_ADD:       e_result = e_a + e_b;
      OP_SUB:       e_result = e_a - e_b;
      OP_AND:       e_result = e_a & e_b;
      OP_LDI:       e_result = de_imm_reg;
      OP_LD, OP_ST: e_result = e_a;
      default:      e_result = '0;
    endcase
  end

  // Pipeline advance, fetch control and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= '0;
      fetch_stop_reg <= 1'b0;
      fd_valid_reg   <= 1'b0;
      fd_instr_reg   <= '0;
      de_reg         <= '0;
      de_rs1_reg     <= '0;
      de_rs2_reg     <= '0;
      de_a_reg       <= '0;
      de_b_reg       <= '0;
      de_imm_reg     <= '0;
      em_reg         <= '0;
      em_result_reg  <= '0;
      em_store_reg   <= '0;
      mw_reg         <= '0;
      mw_result_reg  <= '0;
      halted_reg     <= 1'b0;
      cycle_cnt_reg  <= '0;
      retire_cnt_reg <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      if (!stall) begin
        if (!fetch_stop_reg && !d_hlt) pc_reg <= pc_reg + PC_W'(1);
        fd_valid_reg   <= !fetch_stop_reg && !d_hlt;
        fd_instr_reg   <= imem_data;
        fetch_stop_reg <= fetch_stop_reg || d_hlt;
        de_reg.valid   <= fd_valid_reg;
        de_reg.op      <= d_op;
        de_reg.rd      <= d_rd;
        de_rs1_reg     <= d_rs1;
        de_rs2_reg     <= d_rs2;
        de_a_reg       <= d_a;
        de_b_reg       <= d_b;
        de_imm_reg     <= d_imm;
      end else begin
        de_reg.valid   <= 1'b0;
      end
      em_reg        <= de_reg;
      em_result_reg <= e_result;
      em_store_reg  <= e_b;
      mw_reg        <= em_reg;
      mw_result_reg <= em_result_reg;
      halted_reg    <= halted_reg || w_hlt;
      if (!halted_reg) begin
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        if (w_retire) retire_cnt_reg <= retire_cnt_reg + 32'd1;
        if (stall)    stall_cnt_reg  <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign imem_addr  = pc_reg;
  assign dmem_addr  = em_result_reg[DADDR_W-1:0];
  assign dmem_wdata = em_store_reg;
  assign dmem_we    = em_reg.valid && (em_reg.op == OP_ST) && !rst;
  assign dmem_re    = em_reg.valid && (em_reg.op == OP_LD) && !rst;
  assign dbg_data   = rf_reg[dbg_sel];
  assign halted     = halted_reg || w_hlt;
  assign cycle_cnt  = cycle_cnt_reg;
  assign retire_cnt = retire_cnt_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_pipelined_core.sv
// Scoreboard bench: two cores (forwarding / interlock-only) share one program
// memory; expected stores and end-of-program state are queued and checked.
module tb_pipelined_core;

  localparam int DATA_W  = 32;
  localparam int PC_W    = 10;
  localparam int DADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] imem [1024];

  // forwarding instance
  logic [PC_W-1:0]    f_imem_addr;
  logic [15:0]        f_imem_data;
  logic [DADDR_W-1:0] f_dmem_addr;
  logic [DATA_W-1:0]  f_dmem_wdata;
  logic               f_dmem_we;
  logic               f_dmem_re;
  logic [DATA_W-1:0]  f_dmem_rdata;
  logic [2:0]         f_dbg_sel;
  logic [DATA_W-1:0]  f_dbg_data;
  logic               f_halted;
  logic [31:0]        f_cycle_cnt;
  logic [31:0]        f_retire_cnt;
  logic [31:0]        f_stall_cnt;
  logic [DATA_W-1:0]  f_dmem [1024];

  // interlock-only instance
  logic [PC_W-1:0]    n_imem_addr;
  logic [15:0]        n_imem_data;
  logic [DADDR_W-1:0] n_dmem_addr;
  logic [DATA_W-1:0]  n_dmem_wdata;
  logic               n_dmem_we;
  logic               n_dmem_re;
  logic [2:0]         n_dbg_sel;
  logic [DATA_W-1:0]  n_dbg_data;
  logic               n_halted;
  logic [31:0]        n_cycle_cnt;
  logic [31:0]        n_retire_cnt;
  logic [31:0]        n_stall_cnt;

  assign f_imem_data = imem[f_imem_addr];
  assign n_imem_data = imem[n_imem_addr];

  always @(posedge clk) begin
    if (f_dmem_we) f_dmem[f_dmem_addr] <= f_dmem_wdata;
    if (f_dmem_re) f_dmem_rdata <= f_dmem[f_dmem_addr];
  end

  pipelined_core #(.DATA_W(DATA_W), .PC_W(PC_W), .DADDR_W(DADDR_W), .FORWARD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst),
    .imem_addr(f_imem_addr), .imem_data(f_imem_data),
    .dmem_addr(f_dmem_addr), .dmem_wdata(f_dmem_wdata), .dmem_we(f_dmem_we),
    .dmem_re(f_dmem_re), .dmem_rdata(f_dmem_rdata),
    .dbg_sel(f_dbg_sel), .dbg_data(f_dbg_data), .halted(f_halted),
    .cycle_cnt(f_cycle_cnt), .retire_cnt(f_retire_cnt), .stall_cnt(f_stall_cnt)
  );

  pipelined_core #(.DATA_W(DATA_W), .PC_W(PC_W), .DADDR_W(DADDR_W), .FORWARD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst(rst),
    .imem_addr(n_imem_addr), .imem_data(n_imem_data),
    .dmem_addr(n_dmem_addr), .dmem_wdata(n_dmem_wdata), .dmem_we(n_dmem_we),
    .dmem_re(n_dmem_re), .dmem_rdata('0),
    .dbg_sel(n_dbg_sel), .dbg_data(n_dbg_data), .halted(n_halted),
    .cycle_cnt(n_cycle_cnt), .retire_cnt(n_retire_cnt), .stall_cnt(n_stall_cnt)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } store_t;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [31:0]      ret;
    logic [31:0]      stl;
    logic [3:0][2:0]  r;
    logic [3:0][31:0] v;
  } halt_t;

  store_t store_q[$];
  halt_t  halt_q[$];
  halt_t  nhalt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b100, rd, imm};
  endfunction

  localparam logic [15:0] HLT = 16'hE000;

  // Monitor for the forwarding core: stores and end-of-program state.
  initial begin : mon_fwd
    bit     seen;
    store_t s;
    halt_t  h;
    seen = 1'b0;
    f_dbg_sel = 3'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        if (f_dmem_we) begin
          if (store_q.size() == 0) flag("store_unexpected");
          else begin
            s = store_q.pop_front();
            check("store_addr", 32'(f_dmem_addr), 32'(s.addr));
            check("store_data", f_dmem_wdata, s.data);
          end
        end
        if (f_halted && !seen) begin
          seen = 1'b1;
          @(negedge clk);
          if (halt_q.size() == 0) flag("halt_unexpected");
          else begin
            h = halt_q.pop_front();
            check("fwd_halted_hold", 32'(f_halted), 32'd1);
            check("fwd_cycle_cnt", f_cycle_cnt, h.cyc);
            check("fwd_retire_cnt", f_retire_cnt, h.ret);
            check("fwd_stall_cnt", f_stall_cnt, h.stl);
            for (int i = 0; i < 4; i++) begin
              f_dbg_sel = h.r[i];
              #1;
              check($sformatf("fwd_r%0d", h.r[i]), f_dbg_data, h.v[i]);
            end
          end
        end
      end
    end
  end

  // Monitor for the interlock-only core: end-of-program state when expected.
  initial begin : mon_nofwd
    bit    seen;
    halt_t h;
    seen = 1'b0;
    n_dbg_sel = 3'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (n_halted && !seen) begin
        seen = 1'b1;
        @(negedge clk);
        if (nhalt_q.size() != 0) begin
          h = nhalt_q.pop_front();
          check("nofwd_cycle_cnt", n_cycle_cnt, h.cyc);
          check("nofwd_retire_cnt", n_retire_cnt, h.ret);
          check("nofwd_stall_cnt", n_stall_cnt, h.stl);
          for (int i = 0; i < 4; i++) begin
            n_dbg_sel = h.r[i];
            #1;
            check($sformatf("nofwd_r%0d", h.r[i]), n_dbg_data, h.v[i]);
          end
        end
      end
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input bit both);
    int n;
    n = 0;
    while (!(f_halted && (!both || n_halted)) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) flag("halt_timeout");
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    halt_t h;
    clear_imem();

    // 1: LDI r1,5; LDI r2,3; ADD r3,r1,r2; HLT; (LDI r7 must never run)
    imem[0] = ldi(3'd1, 10'd5);
    imem[1] = ldi(3'd2, 10'd3);
    imem[2] = rr(3'b001, 3'd3, 3'd1, 3'd2);
    imem[3] = HLT;
    imem[4] = ldi(3'd7, 10'h1FF);
    h.cyc = 32'd8;  h.ret = 32'd4; h.stl = 32'd0;
    h.r = {3'd7, 3'd2, 3'd1, 3'd3};
    h.v = {32'd0, 32'd3, 32'd5, 32'd8};
    halt_q.push_back(h);
    h.cyc = 32'd10; h.stl = 32'd2;
    nhalt_q.push_back(h);
    do_reset();
    check("rst_pc", 32'(f_imem_addr), 32'd0);
    check("rst_halted", 32'(f_halted), 32'd0);
    check("rst_cycle_cnt", f_cycle_cnt, 32'd0);
    check("rst_retire_cnt", f_retire_cnt, 32'd0);
    check("rst_dmem_we_re", {30'd0, f_dmem_we, f_dmem_re}, 32'd0);
    wait_halt(1'b1);

    // 2: store then load-use
    clear_imem();
    imem[0] = ldi(3'd1, 10'd20);
    imem[1] = ldi(3'd2, 10'h055);
    imem[2] = rr(3'b110, 3'd0, 3'd1, 3'd2);
    imem[3] = rr(3'b101, 3'd4, 3'd1, 3'd0);
    imem[4] = rr(3'b001, 3'd5, 3'd4, 3'd4);
    imem[5] = HLT;
    store_q.push_back('{addr: 10'd20, data: 32'h55});
    h.cyc = 32'd11; h.ret = 32'd6; h.stl = 32'd1;
    h.r = {3'd2, 3'd1, 3'd4, 3'd5};
    h.v = {32'h55, 32'd20, 32'h55, 32'hAA};
    halt_q.push_back(h);
    do_reset();
    wait_halt(1'b0);

    // 3: wraparound, sign extension, AND, forwarding priority
    clear_imem();
    imem[0] = ldi(3'd2, 10'd1);
    imem[1] = rr(3'b010, 3'd1, 3'd0, 3'd2);
    imem[2] = ldi(3'd6, 10'h3FD);
    imem[3] = rr(3'b011, 3'd7, 3'd6, 3'd2);
    imem[4] = ldi(3'd3, 10'd7);
    imem[5] = ldi(3'd3, 10'd9);
    imem[6] = rr(3'b001, 3'd4, 3'd3, 3'd3);
    imem[7] = HLT;
    h.cyc = 32'd12; h.ret = 32'd8; h.stl = 32'd0;
    h.r = {3'd4, 3'd7, 3'd6, 3'd1};
    h.v = {32'h12, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    halt_q.push_back(h);
    do_reset();
    wait_halt(1'b0);

    // 4: reset while ST is in E; no store may reach memory
    clear_imem();
    imem[0] = ldi(3'd1, 10'd20);
    imem[1] = ldi(3'd2, 10'h055);
    imem[2] = rr(3'b110, 3'd0, 3'd1, 3'd2);
    imem[3] = HLT;
    do_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_cycle_cnt", f_cycle_cnt, 32'd4);
    check("pre_rst_pc", 32'(f_imem_addr), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pc", 32'(f_imem_addr), 32'd0);
    check("midrst_halted", 32'(f_halted), 32'd0);
    check("midrst_cycle_cnt", f_cycle_cnt, 32'd0);
    check("midrst_retire_cnt", f_retire_cnt, 32'd0);
    check("midrst_stall_cnt", f_stall_cnt, 32'd0);
    repeat (3) @(negedge clk);

    // 5: all-NOP program, PC wraps from 1023 to 0
    clear_imem();
    do_reset();
    repeat (1023) @(posedge clk);
    @(negedge clk);
    check("pc_last", 32'(f_imem_addr), 32'd1023);
    @(negedge clk);
    check("pc_wrap", 32'(f_imem_addr), 32'd0);
    check("nop_retire_cnt", f_retire_cnt, 32'd0);
    check("nop_cycle_cnt", f_cycle_cnt, 32'd1024);
    check("nop_halted", 32'(f_halted), 32'd0);

    check("store_q_empty", 32'(store_q.size()), 32'd0);
    check("halt_q_empty", 32'(halt_q.size() + nhalt_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
